// File: rtl/cpi_muldiv_if.sv
// Coprocessor port bundle between the core (master) and a coprocessor (slave).
// Carries the command (valid, inst, belt operands) and the return path
// (ready strobe, wait/busy, result data, drop flag).
interface cpi_muldiv_if;
    logic        cpi_valid;
    logic [31:0] cpi_inst;
    logic [31:0] cpi_r1;
    logic [31:0] cpi_r2;
    logic        cpi_ready;
    logic        cpi_wait;
    logic [31:0] cpi_data;
    logic        cpi_drop;

    modport master (
        output cpi_valid, cpi_inst, cpi_r1, cpi_r2,
        input  cpi_ready, cpi_wait, cpi_data, cpi_drop
    );

    modport slave (
        input  cpi_valid, cpi_inst, cpi_r1, cpi_r2,
        output cpi_ready, cpi_wait, cpi_data, cpi_drop
    );
endinterface

// File: rtl/cpi_muldiv.sv
// Iterative 32-bit multiply/divide coprocessor on the core's cpi port.
// Latency: 33 cycles from accept to the cpi_ready strobe (1 cycle for undefined subops).
// Backpressure: holds cpi_wait while busy; aborts silently if the core drops cpi_valid mid-calc.
// Ports: clk, rst (sync, active-high), cpi (slave side of cpi_muldiv_if).
module cpi_muldiv #(
    parameter logic [3:0] OPCODE = 4'h6
) (
    input  logic         clk,
    input  logic         rst,
    cpi_muldiv_if.slave  cpi
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic        armed;
    logic [4:0]  cnt;
    logic [3:0]  subop;
    // opnd: multiplicand for MUL*, divisor magnitude for DIV*/REM*.
    // p_hi/p_lo: product accumulator, or remainder/quotient-with-dividend.
    logic [31:0] opnd;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        neg_q;
    logic        neg_r;
    logic        b_zero;
    logic        ready_q;
    logic [31:0] data_q;
    logic        drop_q;

    logic        accept;
    logic [3:0]  in_sub;
    logic        in_signed;
    logic        in_mul;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        is_mul;
    logic [32:0] mul_sum;
    logic [33:0] div_diff;
    logic [31:0] nxt_hi;
    logic [31:0] nxt_lo;
    logic [31:0] result;

    assign accept    = cpi.cpi_valid && (cpi.cpi_inst[31:28] == OPCODE) && (state == IDLE) && armed;
    assign in_sub    = cpi.cpi_inst[27:24];
    assign in_signed = (in_sub == 4'd4) || (in_sub == 4'd5);
    assign in_mul    = (in_sub[3:1] == 3'b000);
    assign a_abs     = (in_signed && cpi.cpi_r1[31]) ? -cpi.cpi_r1 : cpi.cpi_r1;
    assign b_abs     = (in_signed && cpi.cpi_r2[31]) ? -cpi.cpi_r2 : cpi.cpi_r2;
    assign is_mul    = (subop[3:1] == 3'b000);

    assign cpi.cpi_wait  = accept || (state == CALC);
    assign cpi.cpi_ready = ready_q;
    assign cpi.cpi_data  = data_q;
    assign cpi.cpi_drop  = drop_q;

    // Multiply consumes B from the LSB of p_lo while the sum shifts in at the top.
    // Divide shifts the dividend out of the top of p_lo into the partial remainder
    // and shifts quotient bits in at the bottom.
    assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : 33'd0);
    assign div_diff = {1'b0, p_hi, p_lo[31]} - {2'b00, opnd};

    always_comb begin
        nxt_hi = p_hi;
        nxt_lo = p_lo;
        if (is_mul) begin
            nxt_hi = mul_sum[32:1];
            nxt_lo = {mul_sum[0], p_lo[31:1]};
        end else if (!div_diff[33]) begin
            nxt_hi = div_diff[31:0];
            nxt_lo = {p_lo[30:0], 1'b1};
        end else begin
            nxt_hi = {p_hi[30:0], p_lo[31]};
            nxt_lo = {p_lo[30:0], 1'b0};
        end
    end

    // Signed fix-up on the final iteration's values. A zero divisor keeps the
    // all-ones quotient unnegated; the remainder path naturally returns A.
    always_comb begin
        result = 32'd0;
        case (subop)
            4'd0:    result = nxt_lo;
            4'd1:    result = nxt_hi;
            4'd2:    result = nxt_lo;
            4'd3:    result = nxt_hi;
            4'd4:    result = (neg_q && !b_zero) ? -nxt_lo : nxt_lo;
            4'd5:    result = neg_r ? -nxt_hi : nxt_hi;
            default: result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            armed   <= 1'b1;
            cnt     <= 5'd0;
            subop   <= 4'd0;
            opnd    <= 32'd0;
            p_hi    <= 32'd0;
            p_lo    <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            b_zero  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= 32'd0;
            drop_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            data_q  <= 32'd0;
            drop_q  <= 1'b0;
            if (!cpi.cpi_valid) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        subop  <= in_sub;
                        neg_q  <= cpi.cpi_r1[31] ^ cpi.cpi_r2[31];
                        neg_r  <= cpi.cpi_r1[31];
                        b_zero <= (cpi.cpi_r2 == 32'd0);
                        opnd   <= in_mul ? cpi.cpi_r1 : b_abs;
                        p_hi   <= 32'd0;
                        p_lo   <= in_mul ? cpi.cpi_r2 : a_abs;
                        cnt    <= 5'd31;
                        if (in_sub > 4'd5) begin
                            state   <= DONE;
                            ready_q <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!cpi.cpi_valid) begin
                        state <= IDLE;
                    end else begin
                        p_hi <= nxt_hi;
                        p_lo <= nxt_lo;
                        cnt  <= cnt - 5'd1;
                        if (cnt == 5'd0) begin
                            state   <= DONE;
                            ready_q <= 1'b1;
                            data_q  <= result;
                            drop_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    // A low cpi_valid in this cycle re-arms, so it wins over the clear.
                    if (cpi.cpi_valid) begin
                        armed <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpi_muldiv.sv
module tb_cpi_muldiv;
    localparam logic [3:0] OP = 4'h6;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic w_hist [0:40];
    logic leak;

    cpi_muldiv_if cif ();

    cpi_muldiv #(.OPCODE(OP)) dut (
        .clk (clk),
        .rst (rst),
        .cpi (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one command, samples the return path once per cycle at negedge,
    // scrambles the operands right after accept. With release_valid set, holds
    // cpi_valid through the strobe cycle and then drops it for one cycle.
    task automatic run_cmd(input logic [3:0] sub, input logic [31:0] a, input logic [31:0] b,
                           input logic release_valid,
                           output int lat, output logic [31:0] dat, output logic drp);
        lat = -1;
        dat = 32'd0;
        drp = 1'b0;
        leak = 1'b0;
        for (int i = 0; i <= 40; i++) w_hist[i] = 1'b0;
        @(negedge clk);
        cif.cpi_valid = 1'b1;
        cif.cpi_inst  = {OP, sub, 24'h000000};
        cif.cpi_r1    = a;
        cif.cpi_r2    = b;
        #1 w_hist[0] = cif.cpi_wait;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            w_hist[i] = cif.cpi_wait;
            if (cif.cpi_ready === 1'b1) begin
                lat = i;
                dat = cif.cpi_data;
                drp = cif.cpi_drop;
            end else if (cif.cpi_data !== 32'd0 || cif.cpi_drop !== 1'b0) begin
                leak = 1'b1;
            end
            if (i == 1) begin
                cif.cpi_r1 = ~a;
                cif.cpi_r2 = 32'h0000_1234;
            end
        end
        if (release_valid) begin
            @(negedge clk);
            cif.cpi_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (cif.cpi_ready !== 1'b0 || cif.cpi_wait !== 1'b0 || cif.cpi_data !== 32'd0 || cif.cpi_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b wait=%b data=%h drop=%b, need all 0",
                     cif.cpi_ready, cif.cpi_wait, cif.cpi_data, cif.cpi_drop);
        end
    endtask

    task automatic test_arith(input string name, input logic [3:0] sub, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
        int lat; logic [31:0] dat; logic drp;
        run_cmd(sub, a, b, 1'b1, lat, dat, drp);
        checks++;
        if (lat !== 33 || dat !== exp || drp !== 1'b1 || leak !== 1'b0) begin
            errors++;
            $display("FAIL %s: lat=%0d data=%h drop=%b leak=%b, need lat=33 data=%h drop=1 leak=0",
                     name, lat, dat, drp, leak, exp);
        end
    endtask

    task automatic test_handshake;
        int lat; logic [31:0] dat; logic drp;
        logic bad;
        run_cmd(4'd0, 32'd3, 32'd5, 1'b0, lat, dat, drp);
        bad = 1'b0;
        for (int i = 0; i <= 32; i++) if (w_hist[i] !== 1'b1) bad = 1'b1;
        checks++;
        if (bad || w_hist[33] !== 1'b0 || lat !== 33 || dat !== 32'd15) begin
            errors++;
            $display("FAIL wait_window: bad=%b wait@33=%b lat=%0d data=%h, need bad=0 wait@33=0 lat=33 data=0000000f",
                     bad, w_hist[33], lat, dat);
        end
        // Core keeps cpi_valid high: no re-accept.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (cif.cpi_wait !== 1'b0 || cif.cpi_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_no_reaccept: cycle %0d wait=%b ready=%b, need 0 0", i, cif.cpi_wait, cif.cpi_ready);
            end
        end
        cif.cpi_valid = 1'b0;
        @(negedge clk);
        cif.cpi_valid = 1'b1;
        #1;
        checks++;
        if (cif.cpi_wait !== 1'b1) begin
            errors++;
            $display("FAIL rearm_accept: wait=%b, need 1", cif.cpi_wait);
        end
        @(negedge clk);
        cif.cpi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] dat; logic drp;
        run_cmd(4'd2, 32'd1000, 32'd10, 1'b1, lat, dat, drp);
        checks++;
        if (lat !== 33 || dat !== 32'd100) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d data=%h, need 33 00000064", lat, dat);
        end
        run_cmd(4'd3, 32'd1000, 32'd7, 1'b1, lat, dat, drp);
        checks++;
        if (w_hist[0] !== 1'b1 || lat !== 33 || dat !== 32'd6) begin
            errors++;
            $display("FAIL b2b_second: wait@0=%b lat=%0d data=%h, need 1 33 00000006", w_hist[0], lat, dat);
        end
    endtask

    task automatic test_undefined;
        int lat; logic [31:0] dat; logic drp;
        run_cmd(4'd9, 32'd123, 32'd456, 1'b1, lat, dat, drp);
        checks++;
        if (lat !== 1 || dat !== 32'd0 || drp !== 1'b0 || w_hist[1] !== 1'b0) begin
            errors++;
            $display("FAIL undefined_subop: lat=%0d data=%h drop=%b wait@1=%b, need 1 00000000 0 0",
                     lat, dat, drp, w_hist[1]);
        end
    endtask

    task automatic test_foreign;
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        cif.cpi_valid = 1'b1;
        cif.cpi_inst  = {4'h7, 4'h0, 24'h000000};
        cif.cpi_r1    = 32'd7;
        cif.cpi_r2    = 32'd6;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cif.cpi_wait !== 1'b0 || cif.cpi_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL foreign_opcode: wait/ready seen high=%b, need 0", bad);
        end
        cif.cpi_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc;
        logic seen;
        @(negedge clk);
        cif.cpi_valid = 1'b1;
        cif.cpi_inst  = {OP, 4'd0, 24'h000000};
        cif.cpi_r1    = 32'd7;
        cif.cpi_r2    = 32'd6;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        cif.cpi_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cif.cpi_ready !== 1'b0 || cif.cpi_wait !== 1'b0 || cif.cpi_data !== 32'd0 || cif.cpi_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_calc: ready=%b wait=%b data=%h drop=%b, need all 0",
                     cif.cpi_ready, cif.cpi_wait, cif.cpi_data, cif.cpi_drop);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cif.cpi_ready !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_strobe: ready seen=%b, need 0", seen);
        end
    endtask

    task automatic test_abort;
        logic seen;
        @(negedge clk);
        cif.cpi_valid = 1'b1;
        cif.cpi_inst  = {OP, 4'd0, 24'h000000};
        cif.cpi_r1    = 32'd9;
        cif.cpi_r2    = 32'd9;
        repeat (5) @(negedge clk);
        cif.cpi_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cif.cpi_wait !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: wait=%b, need 0", cif.cpi_wait);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cif.cpi_ready !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_strobe: ready seen=%b, need 0", seen);
        end
        test_arith("after_abort_divu", 4'd2, 32'd100, 32'd7, 32'd14);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        leak   = 1'b0;
        rst    = 1'b1;
        cif.cpi_valid = 1'b0;
        cif.cpi_inst  = 32'd0;
        cif.cpi_r1    = 32'd0;
        cif.cpi_r2    = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_arith("mul",        4'd0, 32'd7,          32'd6,          32'd42);
        test_arith("mulhu",      4'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
        test_arith("div",        4'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
        test_arith("rem",        4'd5, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
        test_arith("divu",       4'd2, 32'd100,        32'd7,          32'd14);
        test_arith("remu",       4'd3, 32'd100,        32'd7,          32'd2);
        test_arith("divu_by0",   4'd2, 32'd5,          32'd0,          32'hFFFF_FFFF);
        test_arith("remu_by0",   4'd3, 32'd5,          32'd0,          32'd5);
        test_arith("div_ovf",    4'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
        test_arith("rem_ovf",    4'd5, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
        test_arith("div_pos_neg",4'd4, 32'd20,         32'hFFFF_FFFB,  32'hFFFF_FFFC);
        test_handshake();
        test_back_to_back();
        test_undefined();
        test_foreign();
        test_reset_mid_calc();
        test_abort();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
